// File: rtl/div_pkg.sv
// Shared types and defaults for the repeated-subtraction divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } div_state_t;

endpackage

// File: rtl/binary_divider_if.sv
// Load / busy / done handshake plus operand and result buses of the divider.
interface binary_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);

    logic             load;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output load, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  load, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );

endinterface

// File: rtl/quot_counter.sv
// Quotient up-counter: clear on a new division, preset to all ones on divide-by-zero.
module quot_counter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             set_ones,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (set_ones) begin
            q <= '1;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/binary_divider.sv
// Unsigned divider: subtracts the divisor once per cycle, counting subtractions as the quotient.
module binary_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    binary_divider_if.slave  bus
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             div_zero_q, div_zero_d;
    logic             cnt_clr, cnt_set, cnt_en;
    logic             rem_ge_dvsr;
    logic [WIDTH-1:0] quot;

    assign rem_ge_dvsr = (rem_q >= dvsr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load) state_d = (bus.divisor == '0) ? DONE : SUB;
            SUB:     if (!rem_ge_dvsr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        div_zero_d = div_zero_q;
        cnt_clr    = 1'b0;
        cnt_set    = 1'b0;
        cnt_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    rem_d      = bus.dividend;
                    div_zero_d = (bus.divisor == '0);
                    if (bus.divisor == '0) begin
                        cnt_set = 1'b1;
                    end else begin
                        dvsr_d  = bus.divisor;
                        cnt_clr = 1'b1;
                    end
                end
            end
            SUB: begin
                // Guarded by the compare, so the subtraction never wraps.
                if (rem_ge_dvsr) begin
                    rem_d  = rem_q - dvsr_q;
                    cnt_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q      <= '0;
            dvsr_q     <= '0;
            div_zero_q <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            div_zero_q <= div_zero_d;
        end
    end

    quot_counter #(.WIDTH(WIDTH)) u_quot (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (cnt_clr),
        .set_ones (cnt_set),
        .en       (cnt_en),
        .q        (quot)
    );

    assign bus.quotient  = quot;
    assign bus.remainder = rem_q;
    assign bus.busy      = (state_q == SUB);
    assign bus.done      = (state_q == DONE);
    assign bus.div_zero  = div_zero_q;

endmodule
